lane_mem_sequencer: RTL and testbench

//  Per-lane load/store sequencer placed directly upstream of datamem. A SIMD

---
 rtl/lane_mem_sequencer.sv | 107 ++++++++++
 tb/tb_lane_mem_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lane_mem_sequencer.sv
// rtl/lane_mem_sequencer.sv - serialises active SIMD lane loads/stores onto datamem's single port
`ifndef DATAMEM_ADDR_WIDTH
`define DATAMEM_ADDR_WIDTH 8
`endif
`ifndef DATA_WORD_LENGTH
`define DATA_WORD_LENGTH 8
`endif

module lane_mem_sequencer #(
  parameter int N_LANES = 4,
  parameter int ADDR_W  = `DATAMEM_ADDR_WIDTH,
  parameter int DATA_W  = `DATA_WORD_LENGTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [N_LANES-1:0]        lane_mask,
  input  logic [N_LANES*ADDR_W-1:0] lane_addr,
  input  logic [N_LANES*DATA_W-1:0] lane_wdata,
  output logic                      busy,
  output logic                      done,
  output logic [N_LANES*DATA_W-1:0] lane_rdata,
  output logic                      MemWrite,
  output logic [ADDR_W-1:0]         Address,
  output logic [DATA_W-1:0]         WriteData,
  input  logic [DATA_W-1:0]         ReadData
);

  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [N_LANES-1:0]        pending;
  logic [N_LANES-1:0]        pending_rest;
  logic                      op_store;
  logic [N_LANES*ADDR_W-1:0] addr_q;
  logic [N_LANES*DATA_W-1:0] wdata_q;
  logic [LW-1:0]             sel;

  // Pick the lowest pending lane; the descending loop lets the lowest index win.
  // pending_rest is the pending set once that lane has been serviced.
  always_comb begin
    sel = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (pending[i]) sel = LW'(i);
    end
    pending_rest = pending & (pending - N_LANES'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and datamem drive; the bus is only non-zero while a lane is being accessed,
  // and it comes straight from registers so it is stable across the negedge write.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (lane_mask != '0) ? ACCESS : DONE;
      end
      ACCESS: begin
        busy      = 1'b1;
        MemWrite  = op_store;
        Address   = addr_q[int'(sel)*ADDR_W +: ADDR_W];
        WriteData = wdata_q[int'(sel)*DATA_W +: DATA_W];
        if (pending_rest == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on an accepted start, then per-lane retirement and load capture.
  // A start outside IDLE never reaches the latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      op_store   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lane_rdata <= '0;
    end else if (state == IDLE && start) begin
      pending  <= lane_mask;
      op_store <= is_store;
      addr_q   <= lane_addr;
      wdata_q  <= lane_wdata;
    end else if (state == ACCESS) begin
      pending <= pending_rest;
      if (!op_store) lane_rdata[int'(sel)*DATA_W +: DATA_W] <= ReadData;
    end
  end

endmodule

// File: tb/tb_lane_mem_sequencer.sv
// tb/tb_lane_mem_sequencer.sv - scoreboard bench for lane_mem_sequencer
module tb_lane_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [3:0]  lane_mask;
  logic [31:0] lane_addr;
  logic [31:0] lane_wdata;
  logic        busy;
  logic        done;
  logic [31:0] lane_rdata;
  logic        MemWrite;
  logic [7:0]  Address;
  logic [7:0]  WriteData;
  logic [7:0]  ReadData;

  logic [7:0]  ram [256];

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  typedef struct packed {
    int          cyc;
    logic [31:0] rdata;
  } done_t;

  acc_t  acc_q[$];
  done_t done_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_start = 0;

  lane_mem_sequencer #(.N_LANES(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .lane_mask(lane_mask), .lane_addr(lane_addr), .lane_wdata(lane_wdata),
    .busy(busy), .done(done), .lane_rdata(lane_rdata),
    .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // datamem model: combinational read, negedge write
  assign ReadData = ram[Address];
  always @(negedge clk) if (MemWrite) ram[Address] <= WriteData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every bus access and every done pulse is matched against the queues
  always @(negedge clk) begin
    acc_t  a;
    done_t d;
    if (busy) begin
      if (acc_q.size() == 0) begin
        check("unexpected_access", {15'd0, MemWrite, Address, WriteData}, 32'hFFFFFFFF);
      end else begin
        a = acc_q.pop_front();
        check("access", {15'd0, MemWrite, Address, WriteData}, {15'd0, a.we, a.addr, a.wdata});
      end
    end else begin
      check("idle_bus", {15'd0, MemWrite, Address, WriteData}, 32'd0);
    end
    if (done) begin
      check("done_not_busy", {31'd0, busy}, 32'd0);
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        d = done_q.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("done_rdata", lane_rdata, d.rdata);
      end
    end
  end

  task automatic issue(input logic st, input logic [3:0] m, input logic [31:0] a, input logic [31:0] w);
    @(posedge clk); #1;
    start = 1'b1; is_store = st; lane_mask = m; lane_addr = a; lane_wdata = w;
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0; is_store = ~st; lane_mask = ~m; lane_addr = ~a; lane_wdata = ~w;
  endtask

  task automatic push_acc(input logic we, input logic [7:0] ad, input logic [7:0] wd);
    acc_t a;
    a.we = we; a.addr = ad; a.wdata = wd;
    acc_q.push_back(a);
  endtask

  task automatic push_done(input int c, input logic [31:0] r);
    done_t d;
    d.cyc = c; d.rdata = r;
    done_q.push_back(d);
  endtask

  task automatic drain(input string name);
    int n;
    for (n = 0; n < 30; n++) begin
      @(negedge clk); #1;
      if (acc_q.size() == 0 && done_q.size() == 0) break;
    end
    check({name, "_timeout"}, (n >= 30) ? 32'd1 : 32'd0, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i + 16);
    reset = 1'b1; start = 1'b0; is_store = 1'b0;
    lane_mask = '0; lane_addr = '0; lane_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bus", {15'd0, MemWrite, Address, WriteData}, 32'd0);
    check("rst_rdata", lane_rdata, 32'd0);

    // 1: load, mask 1011, lane i addr i
    issue(1'b0, 4'b1011, 32'h03020100, 32'hDEADBEEF);
    push_acc(1'b0, 8'h00, 8'hEF);
    push_acc(1'b0, 8'h01, 8'hBE);
    push_acc(1'b0, 8'h03, 8'hDE);
    push_done(t_start + 4, 32'h13001110);
    drain("t1");

    // 2: store, all lanes, addr i*4
    issue(1'b1, 4'b1111, 32'h0C080400, 32'hA3A2A1A0);
    push_acc(1'b1, 8'h00, 8'hA0);
    push_acc(1'b1, 8'h04, 8'hA1);
    push_acc(1'b1, 8'h08, 8'hA2);
    push_acc(1'b1, 8'h0C, 8'hA3);
    push_done(t_start + 5, 32'h13001110);
    drain("t2");
    check("t2_ram8", {24'd0, ram[8]}, 32'h000000A2);
    check("t2_ram12", {24'd0, ram[12]}, 32'h000000A3);

    // 3: empty mask
    issue(1'b1, 4'b0000, 32'h01010101, 32'hFFFFFFFF);
    push_done(t_start + 1, 32'h13001110);
    drain("t3");
    check("t3_ram1", {24'd0, ram[1]}, 32'h00000011);

    // 4: duplicate store address, then load it back on lanes 1 and 2
    issue(1'b1, 4'b1111, 32'h05050505, 32'h04030201);
    push_acc(1'b1, 8'h05, 8'h01);
    push_acc(1'b1, 8'h05, 8'h02);
    push_acc(1'b1, 8'h05, 8'h03);
    push_acc(1'b1, 8'h05, 8'h04);
    push_done(t_start + 5, 32'h13001110);
    drain("t4s");
    check("t4_ram5", {24'd0, ram[5]}, 32'h00000004);
    issue(1'b0, 4'b0110, 32'h05050505, 32'h00000000);
    push_acc(1'b0, 8'h05, 8'h00);
    push_acc(1'b0, 8'h05, 8'h00);
    push_done(t_start + 3, 32'h13040410);
    drain("t4l");

    // 5: second start during ACCESS is ignored
    issue(1'b0, 4'b0101, 32'h77216620, 32'h00000000);
    push_acc(1'b0, 8'h20, 8'h00);
    push_acc(1'b0, 8'h21, 8'h00);
    push_done(t_start + 3, 32'h13310430);
    start = 1'b1; is_store = 1'b1; lane_mask = 4'b1010;
    lane_addr = 32'h40404040; lane_wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    start = 1'b0;
    drain("t5");
    check("t5_ram40", {24'd0, ram[8'h40]}, 32'h00000050);

    // 6: reset after the first lane of a 4-lane store
    issue(1'b1, 4'b1111, 32'h33323130, 32'hB3B2B1B0);
    push_acc(1'b1, 8'h30, 8'hB0);
    @(negedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_rdata", lane_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t6_ram30", {24'd0, ram[8'h30]}, 32'h000000B0);
    check("t6_ram31", {24'd0, ram[8'h31]}, 32'h00000041);
    check("t6_ram33", {24'd0, ram[8'h33]}, 32'h00000043);
    check("t6_rdata_after", lane_rdata, 32'd0);

    check("acc_q_empty", acc_q.size(), 32'd0);
    check("done_q_empty", done_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
